// File: rtl/fb_sync_reader.sv
`default_nettype none
// ============================================================================
// Module   : fb_sync_reader
// Purpose  : Scans the {x[8:0],y[8:0]} SRAM framebuffer during VGA sync
//            intervals and streams every pixel out on a valid/ready port.
//            Also counts lit pixels (data bit LIT_BIT set) for the scan.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   iCLK, iRST          clock, synchronous active-high reset
//   iStart              one-cycle pulse that begins a scan (ignored when busy)
//   iSync_Window        1 = SRAM bus granted to this block this cycle
//   oAddr, oRead_En     SRAM address {x,y} and address-drive enable
//   iData               SRAM read data, valid the cycle after the address
//   oPix_Valid/iPix_Ready, oPix_X/Y/Data   pixel stream
//   oBusy, oDone        scan in progress / one-cycle end-of-scan pulse
//   oLit_Count          lit pixels in the last or current scan
// Build option
//   FB_READ_SKIP_BLACK_EN  when defined, pixels reading 16'h0000 are not
//                          presented on the stream (count is unaffected).
// ============================================================================
module fb_sync_reader #(
  parameter int X_MAX   = 320,
  parameter int Y_MAX   = 240,
  parameter int LIT_BIT = 15,
  parameter int CNT_W   = 17
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic             iSync_Window,
  output logic [17:0]      oAddr,
  output logic             oRead_En,
  input  logic [15:0]      iData,
  output logic             oPix_Valid,
  input  logic             iPix_Ready,
  output logic [8:0]       oPix_X,
  output logic [8:0]       oPix_Y,
  output logic [15:0]      oPix_Data,
  output logic             oBusy,
  output logic             oDone,
  output logic [CNT_W-1:0] oLit_Count
);

  localparam logic [8:0] C_X_LAST = 9'(X_MAX - 1);
  localparam logic [8:0] C_Y_LAST = 9'(Y_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_OUTPUT  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       x_q, x_d, y_q, y_d;
  logic [17:0]      addr_q, addr_d;
  logic             read_en_q, read_en_d;
  logic             lock_q, lock_d;
  logic             pix_valid_q, pix_valid_d;
  logic [8:0]       pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]      pix_data_q, pix_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] lit_q, lit_d;

  // Raster-order successor of the current pixel.
  logic       w_last;
  logic [8:0] w_x_next, w_y_next;

  always_comb begin
    w_last   = (x_q == C_X_LAST) && (y_q == C_Y_LAST);
    w_x_next = (x_q == C_X_LAST) ? 9'd0 : x_q + 9'd1;
    w_y_next = (x_q == C_X_LAST) ? y_q + 9'd1 : y_q;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    read_en_d   = 1'b0;
    lock_d      = lock_q;
    pix_valid_d = pix_valid_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_data_d  = pix_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    lit_d       = lit_q;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          x_d     = 9'd0;
          y_d     = 9'd0;
          lit_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (iSync_Window) begin
          addr_d    = {x_q, y_q};
          read_en_d = 1'b1;
          lock_d    = 1'b1;
          state_d   = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        // A closed window means the VGA scanout owned the bus and the
        // read data is garbage: retry the same pixel without counting it.
        if (iSync_Window && lock_q) begin
          if (iData[LIT_BIT]) begin
            lit_d = lit_q + CNT_W'(1);
          end
`ifdef FB_READ_SKIP_BLACK_EN
          if (iData == 16'h0000) begin
            if (w_last) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              x_d     = w_x_next;
              y_d     = w_y_next;
              state_d = S_ISSUE;
            end
          end else begin
            pix_data_d  = iData;
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            pix_valid_d = 1'b1;
            state_d     = S_OUTPUT;
          end
`else
          pix_data_d  = iData;
          pix_x_d     = x_q;
          pix_y_d     = y_q;
          pix_valid_d = 1'b1;
          state_d     = S_OUTPUT;
`endif
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_OUTPUT: begin
        if (iPix_Ready) begin
          pix_valid_d = 1'b0;
          if (w_last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            x_d     = w_x_next;
            y_d     = w_y_next;
            state_d = S_ISSUE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!iSync_Window) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      x_q         <= 9'd0;
      y_q         <= 9'd0;
      addr_q      <= 18'd0;
      read_en_q   <= 1'b0;
      lock_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= 9'd0;
      pix_y_q     <= 9'd0;
      pix_data_q  <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lit_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      read_en_q   <= read_en_d;
      lock_q      <= lock_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_data_q  <= pix_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lit_q       <= lit_d;
    end
  end

  // The address drive is released the instant the grant goes away so the
  // top-level mux never fights the VGA scanout.
  assign oRead_En   = read_en_q & iSync_Window;
  assign oAddr      = addr_q;
  assign oPix_Valid = pix_valid_q;
  assign oPix_X     = pix_x_q;
  assign oPix_Y     = pix_y_q;
  assign oPix_Data  = pix_data_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oLit_Count = lit_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_sync_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_sync_reader
// Purpose  : Scoreboard bench for fb_sync_reader on a reduced 20x12 frame.
//            Stimulus tasks push the expected pixel stream; a monitor pops
//            and compares on every handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_sync_reader;

  localparam int XM = 20;
  localparam int YM = 12;
  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          win;
  logic [17:0]   addr;
  logic          rd_en;
  logic [15:0]   rdata;
  logic          pv;
  logic          prdy;
  logic [8:0]    px, py;
  logic [15:0]   pd;
  logic          busy, done;
  logic [CW-1:0] lit;

  fb_sync_reader #(.X_MAX(XM), .Y_MAX(YM), .LIT_BIT(15), .CNT_W(CW)) dut (
    .iCLK(clk), .iRST(rst), .iStart(start), .iSync_Window(win),
    .oAddr(addr), .oRead_En(rd_en), .iData(rdata),
    .oPix_Valid(pv), .iPix_Ready(prdy), .oPix_X(px), .oPix_Y(py),
    .oPix_Data(pd), .oBusy(busy), .oDone(done), .oLit_Count(lit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } pix_t;

  pix_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mode  = 0;
  int   wmode = 0;
  int   done_cnt = 0;
  int   hs_cnt   = 0;
  int   exp_hs   = 0;
  int   exp_lit  = 0;
  bit   drop_armed = 0, drop_hit = 0, retry_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Framebuffer contents per test mode; bit15 is clear except where noted.
  function automatic logic [15:0] mem_rd(input int m, input logic [17:0] a);
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] pat;
    x   = a[17:9];
    y   = a[8:0];
    pat = {1'b0, y[5:0], x};
    case (m)
      0: mem_rd = (x == 9'd10 && y == 9'd6) ? 16'hFFFF : pat;
      1: mem_rd = (x == 9'd5  && y == 9'd0) ? 16'h8005 : pat;
      2: mem_rd = (x == 9'd0  && y == 9'd0) ? 16'h1234 : pat;
      3: mem_rd = (x == 9'd3  && y == 9'd2) ? 16'h8203 : pat;
      default: begin
        if (x == 9'd2 && y == 9'd1)       mem_rd = 16'h8001;
        else if (x == 9'd7 && y == 9'd4)  mem_rd = 16'h0042;
        else if (x == 9'd19 && y == 9'd11) mem_rd = 16'hF00F;
        else                              mem_rd = 16'h0000;
      end
    endcase
  endfunction

  always_comb rdata = mem_rd(mode, addr);

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_busy_low", {63'd0, busy}, 64'd0);
    end
    if (wmode == 2 && drop_hit && rd_en && addr == {9'd5, 9'd0}) retry_seen = 1;
    if (pv && prdy) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pixel: got (%0d,%0d)=%h expected none", px, py, pd);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        check("pix_x", {55'd0, px}, {55'd0, e.x});
        check("pix_y", {55'd0, py}, {55'd0, e.y});
        check("pix_data", {48'd0, pd}, {48'd0, e.d});
      end
    end
  end

  // Sync-window driver.
  initial begin
    int cyc;
    cyc = 0;
    win = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (wmode)
        1: win = (cyc % 5) < 3;
        2: begin
          if (drop_armed && rd_en && addr == {9'd5, 9'd0}) begin
            win = 1'b0;
            drop_armed = 0;
            drop_hit = 1;
            @(negedge clk);
            check("drop_no_valid", {63'd0, pv}, 64'd0);
            check("drop_no_rden", {63'd0, rd_en}, 64'd0);
          end else begin
            win = 1'b1;
          end
        end
        default: win = 1'b1;
      endcase
    end
  end

  task automatic start_scan(input int m);
    logic [15:0] d;
    mode = m;
    exp_q.delete();
    exp_lit = 0;
    for (int y = 0; y < YM; y++) begin
      for (int x = 0; x < XM; x++) begin
        pix_t p;
        d = mem_rd(m, {9'(x), 9'(y)});
        exp_lit += d[15] ? 1 : 0;
`ifdef FB_READ_SKIP_BLACK_EN
        if (d == 16'h0000) continue;
`endif
        p.x = 9'(x); p.y = 9'(y); p.d = d;
        exp_q.push_back(p);
      end
    end
    exp_hs   = exp_q.size();
    done_cnt = 0;
    hs_cnt   = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic finish_scan(input string tag);
    int n;
    n = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no oDone expected oDone", tag);
    end
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_hs"}, 64'(hs_cnt), 64'(exp_hs));
    check({tag, "_lit"}, 64'(lit), 64'(exp_lit));
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_pixel(input int x, input int y, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(pv && px == 9'(x) && py == 9'(y)) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!(pv && px == 9'(x) && py == 9'(y))) begin
      total++; bad++;
      $display("FAIL %s_wait: got no pixel expected (%0d,%0d)", tag, x, y);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; prdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", {addr, rd_en, pv, px, py, pd, busy, done},
          64'd0);
    check("rst_lit", 64'(lit), 64'd0);

    // Full scan, window open, ready high; first-pixel latency.
    mode = 0;
    @(posedge clk); #1 start = 1'b1;
    begin
      pix_t p;
      exp_q.delete();
      exp_lit = 0;
      for (int y = 0; y < YM; y++)
        for (int x = 0; x < XM; x++) begin
          p.x = 9'(x); p.y = 9'(y); p.d = mem_rd(0, {9'(x), 9'(y)});
          exp_lit += p.d[15] ? 1 : 0;
          exp_q.push_back(p);
        end
      exp_hs = exp_q.size(); done_cnt = 0; hs_cnt = 0;
    end
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pv && n < 20);
    check("latency", 64'(n), 64'd3);
    finish_scan("full");

    // Window drop in the capture cycle of (5,0).
    wmode = 2; drop_armed = 1; drop_hit = 0; retry_seen = 0;
    start_scan(1);
    finish_scan("drop");
    check("drop_hit", {63'd0, drop_hit}, 64'd1);
    check("drop_retry", {63'd0, retry_seen}, 64'd1);
    wmode = 0;

    // Ready held low for 10 cycles on (0,0).
    prdy = 1'b0;
    start_scan(2);
    wait_pixel(0, 0, "stall");
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", {rd_en, pv, px, py, pd}, {1'b0, 1'b1, 9'd0, 9'd0, 16'h1234});
      @(negedge clk);
    end
    @(posedge clk); #1 prdy = 1'b1;
    finish_scan("stall");

    // Reset mid-scan at (12,5), then a full rescan.
    start_scan(3);
    wait_pixel(12, 5, "rst");
    check("pre_rst_lit", 64'(lit), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {addr, rd_en, pv, px, py, pd, busy, done}, 64'd0);
    check("midrst_lit", 64'(lit), 64'd0);
    exp_q.delete();
    start_scan(3);
    finish_scan("rescan");

    // iStart mid-scan at (7,3) with a gated window; must be ignored.
    wmode = 1;
    start_scan(0);
    wait_pixel(7, 3, "midstart");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_scan("midstart");
    wmode = 0;

    // Sparse frame: three nonzero pixels, two lit.
    start_scan(4);
    finish_scan("sparse");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_sync_reader.md
Name: fb_sync_reader

Overview:
- Readback counterpart to the pixel-writing state machine: scans the 320x240 SRAM framebuffer, address format {x[8:0],y[8:0]}, and streams every pixel out on a valid/ready interface.
- Accesses SRAM only while the top level grants the bus during VGA sync intervals. The top level muxes oAddr onto SRAM_ADDR whenever oRead_En=1.
- Used for frame capture and for DLA occupancy statistics (lit-pixel count).

Parameters:
- X_MAX, 320, pixels per line; x scans 0..X_MAX-1
- Y_MAX, 240, lines per frame; y scans 0..Y_MAX-1
- LIT_BIT, 15, data bit that marks a pixel as occupied
- CNT_W, 17, width of the lit counter (holds up to 76800)

Ports:
- iCLK  in  1  clock (VGA_CTRL_CLK domain)
- iRST  in  1  synchronous reset, active high
- iStart  in  1  one-cycle pulse that begins a scan
- iSync_Window  in  1  1 = SRAM bus granted (sync active and not paused)
- oAddr  out  18  SRAM address {x,y}
- oRead_En  out  1  1 = block drives SRAM address (WE held high by top)
- iData  in  16  SRAM_DQ read data, valid 1 cycle after address
- oPix_Valid  out  1  pixel output valid
- iPix_Ready  in  1  downstream accepts pixel
- oPix_X  out  9  x of presented pixel
- oPix_Y  out  9  y of presented pixel
- oPix_Data  out  16  pixel word
- oBusy  out  1  scan in progress
- oDone  out  1  one-cycle pulse at scan end
- oLit_Count  out  CNT_W  count of pixels with LIT_BIT=1 in the last or current scan

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: every output is 0, state=IDLE, x=y=0, lock=0.
- iRST mid-scan aborts immediately; there is no partial done.
- IDLE: oBusy=0. On iStart=1, clear x, y and oLit_Count, set oBusy=1, go to ISSUE.
- iStart is ignored while oBusy=1.
- ISSUE:
  - If iSync_Window=1: oAddr<={x,y}, oRead_En<=1, lock<=1, go to CAPTURE.
  - Otherwise stay in ISSUE with oRead_En=0.
- CAPTURE:
  - If iSync_Window=1 and lock=1: oPix_Data<=iData, oPix_X<=x, oPix_Y<=y, oPix_Valid<=1; if iData[LIT_BIT]=1, increment oLit_Count; go to OUTPUT.
  - Otherwise (window closed, so the address was lost to the VGA scanout) go back to ISSUE and retry the same {x,y}.
  - The count is never incremented on a retry.
- lock: cleared in any cycle where iSync_Window=0.
- oRead_En: 0 in any cycle where iSync_Window=0, and 0 in every state other than ISSUE and CAPTURE.
- Read latency: oPix_Valid rises 2 cycles after ISSUE is entered with the window open, provided the window stays open.
- OUTPUT:
  - oPix_Valid and all oPix_* are held stable until iPix_Ready=1.
  - On the handshake: oPix_Valid<=0, then advance x; when x=X_MAX-1, set x<=0 and y<=y+1; go to ISSUE.
  - If the handshake is on the last pixel (x=X_MAX-1, y=Y_MAX-1), go to DONE instead.
  - The window state is irrelevant in OUTPUT.
- DONE: oDone=1 for exactly one cycle, oBusy<=0, go to IDLE. oLit_Count holds until the next iStart or reset.
- Counter width: the counter never wraps (76800 < 2^17).
- Simultaneous iRST and iStart: reset wins.

Optional Feature:
FB_READ_SKIP_BLACK_EN
- Defined: in CAPTURE, a pixel with iData==16'h0000 is not presented. The block advances x/y directly (or goes to DONE on the last pixel) and returns to ISSUE, with no oPix_Valid.
- Undefined: every pixel is presented, X_MAX*Y_MAX handshakes per scan.
- oLit_Count behaviour is identical in both cases.

Test Plan:
- Memory model with only (160,120)=16'hFFFF, window always 1, ready always 1, iStart -> 76800 handshakes in raster order. Pixel (160,120) carries 16'hFFFF. oLit_Count=1, oDone pulses once, oBusy falls the same cycle.
- Window drops in the CAPTURE cycle for pixel (5,0) -> no valid for that cycle. The block re-issues address {5,0} on the next open window and presents its data once. oLit_Count is not double-counted.
- iPix_Ready held 0 for 10 cycles on pixel (0,0)=16'h1234 -> oPix_Valid, X=0, Y=0 and Data=16'h1234 stable for all 10 cycles. oRead_En=0 throughout.
- iRST pulsed while at (100,50) -> next cycle all outputs 0 and state IDLE. A following iStart rescans from (0,0) with the count restarted at 0.
- iStart pulsed at mid-scan (7,3) -> ignored: the scan continues from (8,3) and only one oDone pulse occurs.
- With FB_READ_SKIP_BLACK_EN defined and 3 nonzero pixels -> exactly 3 handshakes, oLit_Count equals the number of those with bit15=1, oDone pulses once.
